// File: rtl/prt_vtb_pkg.sv
// Shared definitions for the video parameter controller: local-bus register map,
// CTL/STATUS bit positions and the stream FSM state type.
package prt_vtb_pkg;

  localparam int unsigned LB_ADR_W = 16;
  localparam int unsigned LB_DAT_W = 32;

  localparam logic [LB_ADR_W-1:0] ADR_CTL    = 16'd0;
  localparam logic [LB_ADR_W-1:0] ADR_IG     = 16'd1;
  localparam logic [LB_ADR_W-1:0] ADR_OG     = 16'd2;
  localparam logic [LB_ADR_W-1:0] ADR_VPS    = 16'd3;
  localparam logic [LB_ADR_W-1:0] ADR_STATUS = 16'd4;

  localparam int unsigned CTL_SEL_LSB = 0;
  localparam int unsigned CTL_IDX_LSB = 8;
  localparam int unsigned CTL_AUTOINC = 16;
  localparam int unsigned CTL_COMMIT  = 17;
  localparam int unsigned CTL_EN      = 18;

  localparam int unsigned STS_PEND      = 0;
  localparam int unsigned STS_STREAMING = 1;
  localparam int unsigned STS_BANK      = 2;
  localparam int unsigned STS_IDX_LSB   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_SWAP
  } vtb_state_e;

endpackage

// File: rtl/prt_dp_lb_if.sv
// Local bus between a bus master and register slaves; the slave drives dout/vld.
interface prt_dp_lb_if;
  import prt_vtb_pkg::*;

  logic [LB_ADR_W-1:0] adr;
  logic                wr;
  logic                rd;
  logic [LB_DAT_W-1:0] din;
  logic [LB_DAT_W-1:0] dout;
  logic                vld;

  modport lb_in  (input adr, wr, rd, din, output dout, vld);
  modport lb_out (output adr, wr, rd, din, input dout, vld);
endinterface

// File: rtl/prt_vtb_vps_bank.sv
// Double-buffered video parameter storage: the local bus sees the shadow bank,
// the stream port sees the active bank; swap only flips the bank id.
module prt_vtb_vps_bank
  import prt_vtb_pkg::*;
#(
  parameter int unsigned P_VPS_DEPTH = 16,
  parameter int unsigned P_VPS_WIDTH = 16,
  localparam int unsigned AW = $clog2(P_VPS_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lb_wr,
  input  logic [AW-1:0]          lb_idx,
  input  logic [P_VPS_WIDTH-1:0] lb_wdat,
  output logic [P_VPS_WIDTH-1:0] lb_rdat,
  input  logic [AW-1:0]          st_idx,
  output logic [P_VPS_WIDTH-1:0] st_dat,
  input  logic                   swap,
  output logic                   bank_id
);

  logic [P_VPS_WIDTH-1:0] mem0 [P_VPS_DEPTH];
  logic [P_VPS_WIDTH-1:0] mem1 [P_VPS_DEPTH];

  // Writes use the pre-swap bank id, so a write coinciding with a swap lands
  // in the bank that is about to become active.
  always_ff @(posedge clk) begin
    if (lb_wr) begin
      if (bank_id) mem0[lb_idx] <= lb_wdat;
      else         mem1[lb_idx] <= lb_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       bank_id <= 1'b0;
    else if (swap) bank_id <= ~bank_id;
  end

  assign lb_rdat = bank_id ? mem0[lb_idx] : mem1[lb_idx];
  assign st_dat  = bank_id ? mem1[st_idx] : mem0[st_idx];

endmodule

// File: rtl/prt_vtb_param_ctl.sv
// Register block with ingress/outgress port windows and a double-buffered
// video parameter set streamed frame by frame over a valid/ready interface.
module prt_vtb_param_ctl
  import prt_vtb_pkg::*;
#(
  parameter int unsigned P_IG_PORTS  = 8,
  parameter int unsigned P_OG_PORTS  = 8,
  parameter int unsigned P_VPS_DEPTH = 16,
  parameter int unsigned P_VPS_WIDTH = 16
) (
  input  logic                           SYS_CLK_IN,
  input  logic                           SYS_RST_IN,
  prt_dp_lb_if.lb_in                     LB_IF,
  input  logic [P_IG_PORTS*32-1:0]       IG_IN,
  output logic [P_OG_PORTS*32-1:0]       OG_OUT,
  output logic [$clog2(P_VPS_DEPTH)-1:0] VPS_IDX_OUT,
  output logic [P_VPS_WIDTH-1:0]         VPS_DAT_OUT,
  output logic                           VPS_VLD_OUT,
  output logic                           VPS_LAST_OUT,
  input  logic                           VPS_RDY_IN
);

  localparam int unsigned AW = $clog2(P_VPS_DEPTH);
  localparam logic [AW-1:0] IDX_LAST = AW'(P_VPS_DEPTH - 1);

  logic [LB_ADR_W-1:0] adr_r;
  logic                wr_r;
  logic                rd_r;
  logic [LB_DAT_W-1:0] din_r;
  logic [LB_DAT_W-1:0] dout_q;
  logic                vld_q;
  logic [LB_DAT_W-1:0] rdata;

  logic [7:0]    sel_q;
  logic [AW-1:0] idx_q;
  logic          ainc_q;
  logic          en_q;
  logic          pend_q;

  logic [31:0] og_q [P_OG_PORTS];
  logic [31:0] ig_word;
  logic [31:0] og_word;

  vtb_state_e    state_q, state_d;
  logic [AW-1:0] st_idx_q, st_idx_d;
  logic          swap;

  logic                   vps_wr;
  logic                   vps_acc;
  logic [P_VPS_WIDTH-1:0] vps_rdat;
  logic [P_VPS_WIDTH-1:0] st_dat;
  logic                   bank_id;

  assign vps_wr  = wr_r && (adr_r == ADR_VPS);
  assign vps_acc = (wr_r || rd_r) && (adr_r == ADR_VPS);

  always_ff @(posedge SYS_CLK_IN) begin
    if (SYS_RST_IN) begin
      adr_r  <= '0;
      wr_r   <= 1'b0;
      rd_r   <= 1'b0;
      din_r  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      adr_r  <= LB_IF.adr;
      wr_r   <= LB_IF.wr;
      rd_r   <= LB_IF.rd;
      din_r  <= LB_IF.din;
      vld_q  <= rd_r;
      dout_q <= rd_r ? rdata : '0;
    end
  end

  assign LB_IF.dout = dout_q;
  assign LB_IF.vld  = vld_q;

  always_ff @(posedge SYS_CLK_IN) begin
    if (SYS_RST_IN) begin
      sel_q  <= '0;
      idx_q  <= '0;
      ainc_q <= 1'b0;
      en_q   <= 1'b0;
    end else if (wr_r && (adr_r == ADR_CTL)) begin
      sel_q  <= din_r[CTL_SEL_LSB +: 8];
      idx_q  <= din_r[CTL_IDX_LSB +: AW];
      ainc_q <= din_r[CTL_AUTOINC];
      en_q   <= din_r[CTL_EN];
    end else if (vps_acc && ainc_q) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // A swap consumes the pending commit; a commit arriving with it adds nothing.
  always_ff @(posedge SYS_CLK_IN) begin
    if (SYS_RST_IN)                                        pend_q <= 1'b0;
    else if (swap)                                         pend_q <= 1'b0;
    else if (wr_r && (adr_r == ADR_CTL) && din_r[CTL_COMMIT]) pend_q <= 1'b1;
  end

  always_ff @(posedge SYS_CLK_IN) begin
    if (SYS_RST_IN) begin
      for (int unsigned i = 0; i < P_OG_PORTS; i++) og_q[i] <= '0;
    end else if (wr_r && (adr_r == ADR_OG)) begin
      for (int unsigned i = 0; i < P_OG_PORTS; i++) begin
        if (sel_q == 8'(i)) og_q[i] <= din_r;
      end
    end
  end

  for (genvar g = 0; g < P_OG_PORTS; g++) begin : g_og
    assign OG_OUT[g*32 +: 32] = og_q[g];
  end

  always_comb begin
    ig_word = '0;
    og_word = '0;
    for (int unsigned i = 0; i < P_IG_PORTS; i++) begin
      if (sel_q == 8'(i)) ig_word = IG_IN[i*32 +: 32];
    end
    for (int unsigned i = 0; i < P_OG_PORTS; i++) begin
      if (sel_q == 8'(i)) og_word = og_q[i];
    end
  end

  always_comb begin
    rdata = '0;
    case (adr_r)
      ADR_CTL: begin
        rdata[CTL_SEL_LSB +: 8] = sel_q;
        rdata[CTL_IDX_LSB +: 8] = 8'(idx_q);
        rdata[CTL_AUTOINC]      = ainc_q;
        rdata[CTL_EN]           = en_q;
      end
      ADR_IG:  rdata = ig_word;
      ADR_OG:  rdata = og_word;
      ADR_VPS: rdata = 32'(vps_rdat);
      ADR_STATUS: begin
        rdata[STS_PEND]         = pend_q;
        rdata[STS_STREAMING]    = (state_q == S_STREAM);
        rdata[STS_BANK]         = bank_id;
        rdata[STS_IDX_LSB +: 8] = 8'(st_idx_q);
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge SYS_CLK_IN) begin
    if (SYS_RST_IN) begin
      state_q  <= S_IDLE;
      st_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      st_idx_q <= st_idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    st_idx_d = st_idx_q;
    swap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        st_idx_d = '0;
        if (pend_q)    state_d = S_SWAP;
        else if (en_q) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (VPS_RDY_IN) begin
          if (st_idx_q == IDX_LAST) begin
            state_d  = S_SWAP;
            st_idx_d = '0;
          end else begin
            st_idx_d = st_idx_q + 1'b1;
          end
        end
      end
      S_SWAP: begin
        swap     = pend_q;
        st_idx_d = '0;
        state_d  = en_q ? S_STREAM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign VPS_VLD_OUT  = (state_q == S_STREAM);
  assign VPS_LAST_OUT = VPS_VLD_OUT && (st_idx_q == IDX_LAST);
  assign VPS_IDX_OUT  = st_idx_q;
  assign VPS_DAT_OUT  = VPS_VLD_OUT ? st_dat : '0;

  prt_vtb_vps_bank #(
    .P_VPS_DEPTH (P_VPS_DEPTH),
    .P_VPS_WIDTH (P_VPS_WIDTH)
  ) u_bank (
    .clk     (SYS_CLK_IN),
    .rst     (SYS_RST_IN),
    .lb_wr   (vps_wr),
    .lb_idx  (idx_q),
    .lb_wdat (din_r[P_VPS_WIDTH-1:0]),
    .lb_rdat (vps_rdat),
    .st_idx  (st_idx_q),
    .st_dat  (st_dat),
    .swap    (swap),
    .bank_id (bank_id)
  );

endmodule

// File: tb/tb_prt_vtb_param_ctl.sv
// Bench for prt_vtb_param_ctl: register/bus behaviour and frame streaming checked
// against a bank-level model (two memories, active id, pending commit).
module tb_prt_vtb_param_ctl;
  import prt_vtb_pkg::*;

  localparam int unsigned NIG = 8;
  localparam int unsigned NOG = 8;
  localparam int unsigned DEP = 16;
  localparam int unsigned WID = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NIG*32-1:0] ig;
  logic [NOG*32-1:0] og;
  logic [3:0]        vidx;
  logic [WID-1:0]    vdat;
  logic              vvld, vlast;
  logic              vrdy = 1'b1;

  prt_dp_lb_if lb ();

  prt_vtb_param_ctl #(
    .P_IG_PORTS  (NIG),
    .P_OG_PORTS  (NOG),
    .P_VPS_DEPTH (DEP),
    .P_VPS_WIDTH (WID)
  ) dut (
    .SYS_CLK_IN   (clk),
    .SYS_RST_IN   (rst),
    .LB_IF        (lb),
    .IG_IN        (ig),
    .OG_OUT       (og),
    .VPS_IDX_OUT  (vidx),
    .VPS_DAT_OUT  (vdat),
    .VPS_VLD_OUT  (vvld),
    .VPS_LAST_OUT (vlast),
    .VPS_RDY_IN   (vrdy)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [WID-1:0] mmem [2][DEP];
  int unsigned    mbid  = 0;
  logic           mpend = 1'b0;
  logic [7:0]     msel  = '0;
  int unsigned    midx  = 0;
  logic           mainc = 1'b0;
  logic           men   = 1'b0;
  logic [31:0]    mog [NOG];

  int unsigned exp_idx    = 0;
  int unsigned mframes    = 0;
  logic        after_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic lb_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    lb.adr = a; lb.din = d; lb.wr = 1'b1;
    @(negedge clk);
    lb.wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic lb_read(input logic [15:0] a, output logic [31:0] d);
    int unsigned n;
    @(negedge clk);
    lb.adr = a; lb.rd = 1'b1;
    @(negedge clk);
    lb.rd = 1'b0;
    n = 1;
    if (!lb.vld) chk("dout_idle", lb.dout, 32'h0);
    while (!lb.vld && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("rd_latency", 32'(n), 32'd2);
    d = lb.dout;
  endtask

  function automatic logic [31:0] ctl_exp();
    logic [31:0] v = '0;
    v[7:0]   = msel;
    v[15:8]  = 8'(midx);
    v[16]    = mainc;
    v[18]    = men;
    return v;
  endfunction

  task automatic ctl_set(input logic [7:0] sel, input int unsigned idx, input logic ainc,
                         input logic commit, input logic en);
    logic [31:0] v = '0;
    v[7:0] = sel; v[15:8] = 8'(idx); v[16] = ainc; v[17] = commit; v[18] = en;
    lb_write(ADR_CTL, v);
    msel = sel; midx = idx % DEP; mainc = ainc; men = en;
    if (commit) mpend = 1'b1;
  endtask

  task automatic vps_wr(input logic [31:0] d);
    lb_write(ADR_VPS, d);
    mmem[1 - mbid][midx] = d[WID-1:0];
    if (mainc) midx = (midx + 1) % DEP;
  endtask

  task automatic vps_rd_chk(input string tag);
    logic [31:0] d;
    lb_read(ADR_VPS, d);
    chk(tag, d, 32'(mmem[1 - mbid][midx]));
    if (mainc) midx = (midx + 1) % DEP;
  endtask

  task automatic wait_beat(input int unsigned k, input string tag);
    int unsigned n = 0;
    @(negedge clk);
    while (!(vvld && 32'(vidx) == k) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(vvld && 32'(vidx) == k), 32'd1);
  endtask

  task automatic wait_frames(input int unsigned target, input string tag);
    int unsigned n = 0;
    while (mframes < target && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(mframes >= target), 32'd1);
  endtask

  // Stream monitor: every valid beat must be the next entry of the active bank.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_idx    = 0;
      after_last = 1'b0;
    end else begin
      if (after_last) chk("swap_gap_vld", 32'(vvld), 32'd0);
      after_last = 1'b0;
      if (vvld) begin
        chk("st_idx", 32'(vidx), exp_idx);
        chk("st_dat", 32'(vdat), 32'(mmem[mbid][exp_idx]));
        chk("st_last", 32'(vlast), 32'(exp_idx == DEP - 1));
        if (vrdy) begin
          if (exp_idx == DEP - 1) begin
            exp_idx    = 0;
            after_last = 1'b1;
            mframes++;
            if (mpend) begin
              mbid  = 1 - mbid;
              mpend = 1'b0;
            end
          end else begin
            exp_idx++;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  sel;
    int unsigned lows, n, f0;

    lb.adr = '0; lb.din = '0; lb.wr = 1'b0; lb.rd = 1'b0;
    for (int i = 0; i < NIG; i++) ig[i*32 +: 32] = $urandom;
    for (int i = 0; i < NOG; i++) mog[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(vvld), 32'd0);
    chk("rst_last", 32'(vlast), 32'd0);
    chk("rst_idx", 32'(vidx), 32'd0);
    chk("rst_dat", 32'(vdat), 32'd0);
    rst = 1'b0;

    lb_read(ADR_CTL, d);    chk("rst_ctl", d, 32'h0);
    lb_read(ADR_STATUS, d); chk("rst_status", d, 32'h0);
    lb_read(ADR_OG, d);     chk("rst_og0", d, 32'h0);
    chk("rst_og_vec", og[31:0], 32'h0);
    lb_write(16'd7, 32'hDEADBEEF);
    lb_read(16'd7, d);      chk("unmapped_rd", d, 32'h0);

    // Auto-increment wrap at the last index.
    ctl_set(8'd0, 15, 1'b1, 1'b0, 1'b0);
    vps_wr(32'h0000A5A5);
    vps_wr(32'h00001234);
    lb_read(ADR_CTL, d); chk("ainc_ctl", d, ctl_exp());
    chk("ainc_idx_model", 32'(midx), 32'd1);
    ctl_set(8'd0, 15, 1'b1, 1'b0, 1'b0);
    vps_rd_chk("shadow15");
    vps_rd_chk("shadow0");
    lb_read(ADR_CTL, d); chk("ainc_ctl_rd", d, ctl_exp());

    // Port windows, including an out-of-range select.
    for (int it = 0; it < 10; it++) begin
      sel = (it == 0) ? 8'd12 : 8'($urandom_range(0, 15));
      ctl_set(sel, 0, 1'b0, 1'b0, 1'b0);
      d = $urandom;
      lb_write(ADR_OG, d);
      if (sel < NOG) mog[sel] = d;
      lb_read(ADR_OG, d);
      chk("og_rd", d, (sel < NOG) ? mog[sel] : 32'h0);
      lb_read(ADR_IG, d);
      chk("ig_rd", d, (sel < NIG) ? ig[sel*32 +: 32] : 32'h0);
    end
    for (int i = 0; i < NOG; i++) chk("og_vec", og[i*32 +: 32], mog[i]);

    // Fill shadow, commit from idle with stream enable.
    ctl_set(8'd0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEP; i++) vps_wr(32'h100 + 32'(i));
    ctl_set(8'd0, 0, 1'b0, 1'b1, 1'b1);
    mbid  = 1 - mbid;
    mpend = 1'b0;
    chk("pre_swap_vld", 32'(vvld), 32'd0);
    @(negedge clk); chk("swap_cyc_vld", 32'(vvld), 32'd0);
    @(negedge clk); chk("frame_start_vld", 32'(vvld), 32'd1);
    chk("frame_start_idx", 32'(vidx), 32'd0);
    chk("frame_start_dat", 32'(vdat), 32'h100);
    wait_frames(1, "frame1_done");
    lb_read(ADR_STATUS, d); chk("status_bank1", d & 32'h5, 32'(mbid) << 2);

    // Backpressure hold at index 7.
    wait_beat(7, "wait_idx7");
    vrdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_idx", 32'(vidx), 32'd7);
      chk("hold_dat", 32'(vdat), 32'(mmem[mbid][7]));
    end
    vrdy = 1'b1;

    // New shadow contents while streaming, then commit mid-frame.
    ctl_set(8'd0, 0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DEP; i++) vps_wr($urandom);
    wait_beat(3, "wait_idx3");
    f0 = mframes;
    ctl_set(8'd0, midx, 1'b1, 1'b1, 1'b1);
    lb_read(ADR_STATUS, d); chk("status_pend_mid", d & 32'h5, (32'(mbid) << 2) | 32'd1);
    wait_frames(f0 + 2, "commit_frames");
    lb_read(ADR_STATUS, d); chk("status_pend_clr", d & 32'h5, 32'(mbid) << 2);

    // Random backpressure, then stop mid-frame.
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      vrdy = 1'($urandom_range(0, 1));
    end
    ctl_set(8'd0, midx, 1'b1, 1'b0, 1'b0);
    lows = 0; n = 0;
    while (lows < 4 && n < 400) begin
      @(negedge clk);
      vrdy = 1'($urandom_range(0, 1));
      lows = vvld ? 0 : lows + 1;
      n++;
    end
    chk("stop_idle", 32'(lows >= 4), 32'd1);
    chk("stop_frame_whole", exp_idx, 32'd0);
    vrdy = 1'b1;
    lb_read(ADR_STATUS, d); chk("status_idle", d, 32'(mbid) << 2);

    // Reset mid-frame at index 9.
    ctl_set(8'd12, midx, 1'b0, 1'b0, 1'b1);
    wait_beat(9, "wait_idx9");
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_vld", 32'(vvld), 32'd0);
    chk("rstmid_last", 32'(vlast), 32'd0);
    chk("rstmid_idx", 32'(vidx), 32'd0);
    chk("rstmid_dat", 32'(vdat), 32'd0);
    rst = 1'b0;
    mbid = 0; mpend = 1'b0; msel = '0; midx = 0; mainc = 1'b0; men = 1'b0;
    for (int i = 0; i < NOG; i++) mog[i] = '0;
    lb_read(ADR_STATUS, d); chk("rstmid_status", d, 32'h0);
    lb_read(ADR_CTL, d);    chk("rstmid_ctl", d, ctl_exp());
    for (int i = 0; i < NOG; i++) chk("rstmid_og", og[i*32 +: 32], mog[i]);
    ctl_set(8'd0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEP; i++) vps_rd_chk("bank_kept");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
